dmem_lsu: RTL and testbench

- Load/store initiator for the data memory: the hardware master that drives the `daddr`/`we`/`indata` inputs of `dmem` and consumes its `outdata`. It takes over the role the VIO debug path plays on the bench.
- Accepts byte, half-word and word load/store requests over a valid/ready handshake.
- Generates byte-lane write enables and replicated store data.
- Waits out the memory read latency, then extracts and sign/zero-extends load data.
- Returns one response per request. Sits between the future CPU datapath and `dmem`.

---
 rtl/dmem_lsu.sv | 190 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store initiator for dmem: byte/half/word requests in, one response out.
// Builds lane enables and replicated store data, waits out read latency, extends load data.
module dmem_lsu #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] dmem_daddr,
   output logic [3:0]        dmem_we,
   output logic [DATA_W-1:0] dmem_indata,
   input  logic [DATA_W-1:0] dmem_outdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_STORE = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        lo_q, lo_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] daddr_q, daddr_d;
   logic [3:0]        we_q, we_d;
   logic [DATA_W-1:0] indata_q, indata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              misalign_c;
   logic [3:0]        base_mask_c;
   logic [DATA_W-1:0] st_data_c;
   logic [7:0]        ld_byte_c;
   logic [15:0]       ld_half_c;
   logic [DATA_W-1:0] ld_data_c;

   assign req_ready   = (state_q == S_IDLE) && rstn;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign dmem_daddr  = daddr_q;
   assign dmem_we     = we_q;
   assign dmem_indata = indata_q;

   // Request decode: alignment check, lane mask and replicated store data
   always_comb begin
      misalign_c  = 1'b0;
      base_mask_c = 4'b1111;
      st_data_c   = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            base_mask_c = 4'b0001;
            st_data_c   = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            misalign_c  = req_addr[0];
            base_mask_c = 4'b0011;
            st_data_c   = {2{req_wdata[15:0]}};
         end
         SZ_WORD: misalign_c = (req_addr[1:0] != 2'b00);
         default: misalign_c = 1'b1;
      endcase
   end

   // Load lane extraction and sign/zero extension
   always_comb begin
      case (lo_q)
         2'd0:    ld_byte_c = dmem_outdata[7:0];
         2'd1:    ld_byte_c = dmem_outdata[15:8];
         2'd2:    ld_byte_c = dmem_outdata[23:16];
         default: ld_byte_c = dmem_outdata[31:24];
      endcase
      ld_half_c = lo_q[1] ? dmem_outdata[31:16] : dmem_outdata[15:0];
      case (size_q)
         SZ_BYTE: ld_data_c = uns_q ? {24'd0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
         SZ_HALF: ld_data_c = uns_q ? {16'd0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
         default: ld_data_c = dmem_outdata;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lo_d        = lo_q;
      size_d      = size_q;
      uns_d       = uns_q;
      daddr_d     = daddr_q;
      we_d        = 4'b0000;
      indata_d    = indata_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               lo_d   = req_addr[1:0];
               size_d = req_size;
               uns_d  = req_unsigned;
               if (misalign_c) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rdata_d     = '0;
                  err_d       = 1'b1;
               end else if (req_we) begin
                  state_d  = S_STORE;
                  daddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                  we_d     = base_mask_c << req_addr[1:0];
                  indata_d = st_data_c;
               end else begin
                  state_d = S_LOAD;
                  daddr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  cnt_d   = 2'd0;
               end
            end
         end
         S_STORE: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b0;
         end
         S_LOAD: begin
            if (cnt_q == LAST_CNT) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rdata_d     = ld_data_c;
               err_d       = 1'b0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         lo_q        <= 2'd0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         daddr_q     <= '0;
         we_q        <= 4'b0000;
         indata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lo_q        <= lo_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         daddr_q     <= daddr_d;
         we_q        <= we_d;
         indata_q    <= indata_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (RD_LAT 1..3), each with its own dmem model;
// one instance is selected at a time and responses are checked against a scoreboard.
module tb_dmem_lsu;

   logic        clk;
   logic        rstn;
   logic [1:0]  sel;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;

   logic [2:0]       req_ready_v;
   logic [2:0]       rsp_valid_v;
   logic [2:0]       rsp_err_v;
   logic [2:0][31:0] rsp_rdata_v;
   logic [2:0][31:0] daddr_v;
   logic [2:0][3:0]  we_v;
   logic [2:0][31:0] indata_v;
   logic [2:0][31:0] outdata_v;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rdata, m_daddr, m_indata;
   logic [3:0]  m_we;

   assign m_req_ready = req_ready_v[sel];
   assign m_rsp_valid = rsp_valid_v[sel];
   assign m_rsp_err   = rsp_err_v[sel];
   assign m_rdata     = rsp_rdata_v[sel];
   assign m_daddr     = daddr_v[sel];
   assign m_we        = we_v[sel];
   assign m_indata    = indata_v[sel];

   int n_cmp = 0;
   int n_err = 0;
   logic [32:0] sb [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_lsu
      logic [31:0] mem [0:63];
      logic [31:0] ap0, ap1, rd_addr;

      dmem_lsu #(.ADDR_W(32), .DATA_W(32), .RD_LAT(k + 1)) u_dut (
         .clk          (clk),
         .rstn         (rstn),
         .req_valid    (req_valid && (sel == 2'(k))),
         .req_ready    (req_ready_v[k]),
         .req_we       (req_we),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_addr     (req_addr),
         .req_wdata    (req_wdata),
         .rsp_valid    (rsp_valid_v[k]),
         .rsp_ready    (rsp_ready && (sel == 2'(k))),
         .rsp_rdata    (rsp_rdata_v[k]),
         .rsp_err      (rsp_err_v[k]),
         .dmem_daddr   (daddr_v[k]),
         .dmem_we      (we_v[k]),
         .dmem_indata  (indata_v[k]),
         .dmem_outdata (outdata_v[k])
      );

      // dmem model: lane writes on posedge (inhibited while system reset is low);
      // read data for an address appears RD_LAT-1 cycles after it is presented
      always_ff @(posedge clk) begin
         ap0 <= daddr_v[k];
         ap1 <= ap0;
         if (rstn) begin
            for (int i = 0; i < 4; i++) begin
               if (we_v[k][i]) mem[daddr_v[k][7:2]][8*i +: 8] <= indata_v[k][8*i +: 8];
            end
         end
      end
      assign rd_addr      = (k == 0) ? daddr_v[k] : ((k == 1) ? ap0 : ap1);
      assign outdata_v[k] = mem[rd_addr[7:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request/response transaction on instance k; hold = cycles rsp_ready stays low
   task automatic do_req(input logic [1:0] k, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_we, input logic [31:0] exp_daddr,
                         input logic [31:0] exp_indata, input int hold, input string tag);
      int          cyc, exp_cyc, we_cnt;
      logic        seen;
      logic [3:0]  we_s;
      logic [31:0] da_s, in_s, da_first;
      logic [32:0] e;
      exp_cyc = exp_err ? 2 : (we ? 3 : 3 + int'(k));
      @(negedge clk);
      sel          = k;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      rsp_ready    = (hold == 0);
      chk({tag, "/req_ready"}, 32'(m_req_ready), 32'd1);
      sb.push_back({exp_err, exp_rdata});
      cyc = 1; seen = 1'b0; we_cnt = 0;
      we_s = '0; da_s = '0; in_s = '0; da_first = '0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         req_valid = 1'b0;
         cyc++;
         if (cyc == 2) da_first = m_daddr;
         if (m_we != 4'b0000) begin
            we_cnt++;
            we_s = m_we;
            da_s = m_daddr;
            in_s = m_indata;
         end
         seen = m_rsp_valid;
      end
      chk({tag, "/latency"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "/we_cycles"}, 32'(we_cnt), (exp_we != 4'b0000) ? 32'd1 : 32'd0);
      if (exp_we != 4'b0000) begin
         chk({tag, "/we"}, 32'(we_s), 32'(exp_we));
         chk({tag, "/st_daddr"}, da_s, exp_daddr);
         chk({tag, "/st_indata"}, in_s, exp_indata);
      end else if (!exp_err) begin
         chk({tag, "/ld_daddr"}, da_first, exp_daddr);
      end
      repeat (hold) begin
         chk({tag, "/hold_valid"}, 32'(m_rsp_valid), 32'd1);
         chk({tag, "/hold_rdata"}, m_rdata, sb[0][31:0]);
         chk({tag, "/hold_req_ready"}, 32'(m_req_ready), 32'd0);
         chk({tag, "/hold_we"}, 32'(m_we), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      chk({tag, "/rsp_valid"}, 32'(m_rsp_valid), 32'd1);
      e = sb.pop_front();
      chk({tag, "/rdata"}, m_rdata, e[31:0]);
      chk({tag, "/err"}, 32'(m_rsp_err), 32'(e[32]));
      @(negedge clk);
      chk({tag, "/post_valid"}, 32'(m_rsp_valid), 32'd0);
      chk({tag, "/post_req_ready"}, 32'(m_req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; sel = 2'd0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst/req_ready", 32'(m_req_ready), 32'd0);
      chk("rst/rsp_valid", 32'(m_rsp_valid), 32'd0);
      chk("rst/rdata", m_rdata, 32'd0);
      chk("rst/err", 32'(m_rsp_err), 32'd0);
      chk("rst/daddr", m_daddr, 32'd0);
      chk("rst/we", 32'(m_we), 32'd0);
      chk("rst/indata", m_indata, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst/req_ready_rel", 32'(m_req_ready), 32'd1);

      // RD_LAT=1: stores then loads of the merged word
      do_req(2'd0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'h10, 32'hDEADBEEF, 0, "sw10");
      do_req(2'd0, 1, 2'b00, 0, 32'h13, 32'h000000A5, 32'h0, 0, 4'b1000, 32'h10, 32'hA5A5A5A5, 0, "sb13");
      do_req(2'd0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b0, 32'h10, 32'h0, 0, "lw10");
      do_req(2'd0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 4'b0, 32'h10, 32'h0, 0, "lb13");
      do_req(2'd0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000A5, 0, 4'b0, 32'h10, 32'h0, 0, "lbu13");
      do_req(2'd0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFA5AD, 0, 4'b0, 32'h10, 32'h0, 0, "lh12");
      do_req(2'd0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, 4'b0, 32'h10, 32'h0, 0, "lhu10");
      do_req(2'd0, 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 4'b0, 32'h10, 32'h0, 0, "lb11");
      do_req(2'd0, 0, 2'b00, 1, 32'h12, 32'h0, 32'h000000AD, 0, 4'b0, 32'h10, 32'h0, 0, "lbu12");
      do_req(2'd0, 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 4'b0, 32'h10, 32'h0, 0, "lb10");
      do_req(2'd0, 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 4'b0, 32'h10, 32'h0, 0, "lh10");
      do_req(2'd0, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000A5AD, 0, 4'b0, 32'h10, 32'h0, 0, "lhu12");

      // misaligned and reserved-size requests, load and store
      do_req(2'd0, 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "err_lh11");
      do_req(2'd0, 1, 2'b01, 0, 32'h11, 32'hFFFF, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "err_sh11");
      do_req(2'd0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "err_lw12");
      do_req(2'd0, 1, 2'b10, 0, 32'h12, 32'h1, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "err_sw12");
      do_req(2'd0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "err_l3");
      do_req(2'd0, 1, 2'b11, 0, 32'h10, 32'h2, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "err_s3");
      do_req(2'd0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b0, 32'h10, 32'h0, 0, "lw10_after_err");

      // upper half-word lanes at 0x14
      do_req(2'd0, 1, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 4'b1111, 32'h14, 32'h0, 0, "sw14");
      do_req(2'd0, 1, 2'b01, 0, 32'h16, 32'h1234C0DE, 32'h0, 0, 4'b1100, 32'h14, 32'hC0DEC0DE, 0, "sh16");
      do_req(2'd0, 0, 2'b10, 0, 32'h14, 32'h0, 32'hC0DE0000, 0, 4'b0, 32'h14, 32'h0, 0, "lw14");
      do_req(2'd0, 0, 2'b01, 0, 32'h16, 32'h0, 32'hFFFFC0DE, 0, 4'b0, 32'h14, 32'h0, 0, "lh16");
      do_req(2'd0, 0, 2'b01, 1, 32'h14, 32'h0, 32'h00000000, 0, 4'b0, 32'h14, 32'h0, 0, "lhu14");

      // response back-pressure
      do_req(2'd0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b0, 32'h10, 32'h0, 5, "lw10_hold");

      // reset during the STORE cycle
      @(negedge clk);
      sel = 2'd0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h12345678; rsp_ready = 1'b1;
      chk("rstmid/req_ready", 32'(m_req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid/we_store", 32'(m_we), 32'hF);
      rstn = 1'b0;
      @(negedge clk);
      chk("rstmid/we", 32'(m_we), 32'd0);
      chk("rstmid/daddr", m_daddr, 32'd0);
      chk("rstmid/indata", m_indata, 32'd0);
      chk("rstmid/rsp_valid", 32'(m_rsp_valid), 32'd0);
      chk("rstmid/rdata", m_rdata, 32'd0);
      chk("rstmid/err", 32'(m_rsp_err), 32'd0);
      chk("rstmid/req_ready", 32'(m_req_ready), 32'd0);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rstmid/no_rsp", 32'(m_rsp_valid), 32'd0);
      end
      chk("rstmid/req_ready_rel", 32'(m_req_ready), 32'd1);
      do_req(2'd0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b0, 32'h10, 32'h0, 0, "rstmid_lw10");

      // longer read latencies
      for (int k = 1; k < 3; k++) begin
         do_req(2'(k), 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'h10, 32'hDEADBEEF, 0, "lat_sw10");
         do_req(2'(k), 1, 2'b00, 0, 32'h13, 32'h000000A5, 32'h0, 0, 4'b1000, 32'h10, 32'hA5A5A5A5, 0, "lat_sb13");
         do_req(2'(k), 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b0, 32'h10, 32'h0, 5, "lat_lw10_hold");
         do_req(2'(k), 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 4'b0, 32'h10, 32'h0, 0, "lat_lb13");
         do_req(2'(k), 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, 4'b0, 32'h10, 32'h0, 0, "lat_lhu10");
         do_req(2'(k), 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0, "lat_err_lw12");
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
